// File: rtl/bound_flasher_pkg.sv
// rtl/bound_flasher_pkg.sv - shared state encoding and lamp-count targets for the bounce pattern
package bound_flasher_pkg;

  localparam int NUM_LEDS = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    UP1  = 3'd1,
    DN1  = 3'd2,
    UP2  = 3'd3,
    DN2  = 3'd4,
    UP3  = 3'd5,
    DN3  = 3'd6
  } state_t;

  localparam logic [4:0] MIN0  = 5'd0;
  localparam logic [4:0] MAX1  = 5'd6;
  localparam logic [4:0] MAX2  = 5'd11;
  localparam logic [4:0] MIN2  = 5'd5;
  localparam logic [4:0] MAX3  = 5'd16;
  localparam logic [4:0] KB_LO = 5'd6;
  localparam logic [4:0] KB_HI = 5'd11;

endpackage

// File: rtl/bound_flasher_if.sv
// rtl/bound_flasher_if.sv - lamp-count to lamp-bar link between the controller and the decoder
interface bound_flasher_if;

  logic [4:0]  cnt;
  logic [15:0] led;

  modport dec_src  (output cnt, input led);
  modport dec_sink (input cnt, output led);

endinterface

// File: rtl/led_thermo_dec.sv
// rtl/led_thermo_dec.sv - lamp count to thermometer-coded lamp bar
module led_thermo_dec
  import bound_flasher_pkg::*;
(
  bound_flasher_if.dec_sink bus
);

  // Lamp i is lit whenever fewer than cnt lamps sit below it; cnt 16 lights all.
  always_comb begin
    bus.led = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      bus.led[i] = (5'(i) < bus.cnt);
    end
  end

endmodule

// File: rtl/bound_flasher.sv
// rtl/bound_flasher.sv - bounce-pattern lamp bar controller with flick-driven kickbacks
module bound_flasher
  import bound_flasher_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flick,
  output logic [15:0] LED
);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  bound_flasher_if dec_bus ();

  assign dec_bus.cnt = cnt_q;
  assign LED         = dec_bus.led;

  led_thermo_dec u_dec (
    .bus (dec_bus)
  );

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      cnt_q   <= MIN0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Turn-arounds load the neighbouring count directly so every edge moves cnt by one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flick) begin
          state_d = UP1;
          cnt_d   = 5'd1;
        end else begin
          cnt_d = MIN0;
        end
      end
      UP1: begin
        if (cnt_q >= MAX1) begin
          state_d = DN1;
          cnt_d   = MAX1 - 5'd1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DN1: begin
        if (cnt_q == MIN0) begin
          state_d = UP2;
          cnt_d   = MIN0 + 5'd1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      UP2: begin
        if (flick && (cnt_q == KB_LO || cnt_q == KB_HI)) begin
          state_d = DN1;
          cnt_d   = cnt_q - 5'd1;
        end else if (cnt_q >= MAX2) begin
          state_d = DN2;
          cnt_d   = MAX2 - 5'd1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DN2: begin
        if (cnt_q <= MIN2) begin
          state_d = UP3;
          cnt_d   = MIN2 + 5'd1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      UP3: begin
        if (flick && cnt_q == KB_HI) begin
          state_d = DN2;
          cnt_d   = KB_HI - 5'd1;
        end else if (cnt_q >= MAX3) begin
          state_d = DN3;
          cnt_d   = MAX3 - 5'd1;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      DN3: begin
        if (cnt_q == MIN0) begin
          state_d = IDLE;
          cnt_d   = MIN0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = MIN0;
      end
    endcase
  end

endmodule

// File: tb/tb_bound_flasher.sv
// tb/tb_bound_flasher.sv - directed bench for the bound_flasher bounce pattern
module tb_bound_flasher;

  logic clk;
  logic rst_n;
  logic flick;
  int   total;
  int   bad;

  bound_flasher_if probe ();

  bound_flasher dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flick (flick),
    .LED   (probe.led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] thermo(input int c);
    logic [16:0] t;
    t = (17'd1 << c) - 17'd1;
    return t[15:0];
  endfunction

  task automatic check_led(input logic [15:0] want, input string tag);
    total++;
    assert (probe.led === want) else begin
      bad++;
      $error("FAIL %s: LED=%h expected %h", tag, probe.led, want);
    end
  endtask

  task automatic step(input int c, input string tag);
    @(negedge clk);
    check_led(thermo(c), tag);
  endtask

  task automatic seg(input int a, input int b, input string tag);
    if (a <= b) begin
      for (int i = a; i <= b; i++) step(i, tag);
    end else begin
      for (int i = a; i >= b; i--) step(i, tag);
    end
  endtask

  task automatic start_pattern(input string tag);
    flick = 1'b1;
    @(negedge clk);
    flick = 1'b0;
    check_led(thermo(1), tag);
  endtask

  task automatic idle_hold(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    flick = 1'b0;
    rst_n = 1'b1;
    #2;
    check_led(16'h0000, "reset_in");
    #4;
    rst_n = 1'b0;

    // 1: no flick, lamps stay dark
    idle_hold(100, "idle_no_flick");

    // 2: single flick runs the full pattern once
    start_pattern("t2_start");
    seg(2, 6, "t2_up1");
    check_led(16'h003F, "t2_peak1");
    seg(5, 0, "t2_dn1");
    seg(1, 11, "t2_up2");
    check_led(16'h07FF, "t2_peak2");
    seg(10, 5, "t2_dn2");
    seg(6, 16, "t2_up3");
    check_led(16'hFFFF, "t2_peak3");
    seg(15, 0, "t2_dn3");
    idle_hold(4, "t2_idle");

    // 3: flick held, UP2 kicks back at 6 every pass
    flick = 1'b1;
    @(negedge clk);
    check_led(thermo(1), "t3_start");
    seg(2, 6, "t3_up1");
    seg(5, 0, "t3_dn1");
    for (int p = 0; p < 3; p++) begin
      seg(1, 6, "t3_up2_kb");
      seg(5, 0, "t3_dn1_kb");
    end
    flick = 1'b0;
    seg(1, 11, "t3_up2");
    seg(10, 5, "t3_dn2");
    seg(6, 16, "t3_up3");
    seg(15, 0, "t3_dn3");
    idle_hold(2, "t3_idle");

    // 4: flick only at UP3 cnt 11 -> kickback to DN2
    start_pattern("t4_start");
    seg(2, 6, "t4_up1");
    seg(5, 0, "t4_dn1");
    seg(1, 11, "t4_up2");
    seg(10, 5, "t4_dn2");
    seg(6, 11, "t4_up3a");
    flick = 1'b1;
    step(10, "t4_kickback");
    flick = 1'b0;
    seg(9, 5, "t4_dn2b");
    check_led(16'h001F, "t4_floor");
    seg(6, 16, "t4_up3b");
    seg(15, 0, "t4_dn3");
    idle_hold(2, "t4_idle");

    // 5: flick at UP2 cnt 8 is not a check point
    start_pattern("t5_start");
    seg(2, 6, "t5_up1");
    seg(5, 0, "t5_dn1");
    seg(1, 8, "t5_up2a");
    flick = 1'b1;
    step(9, "t5_no_kick");
    flick = 1'b0;
    seg(10, 11, "t5_up2b");
    seg(10, 5, "t5_dn2");
    seg(6, 16, "t5_up3");
    seg(15, 0, "t5_dn3");
    idle_hold(2, "t5_idle");

    // 6: async reset mid-pattern at LED 01FF
    start_pattern("t6_start");
    seg(2, 6, "t6_up1");
    seg(5, 0, "t6_dn1");
    seg(1, 9, "t6_up2");
    check_led(16'h01FF, "t6_pre_rst");
    #2;
    rst_n = 1'b1;
    #1;
    check_led(16'h0000, "t6_async_rst");
    @(negedge clk);
    check_led(16'h0000, "t6_rst_held");
    rst_n = 1'b0;
    idle_hold(5, "t6_post_rst_idle");
    start_pattern("t6_restart");
    step(2, "t6_restart2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
